// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-subset control FSM: registered 4-bit state, Moore strobes,
// with pc_we qualified by the ALU zero flag and FETCH gated by run.
module mc_ctrl_fsm #(
    parameter int OPW = 6,
    parameter int SW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           pc_we,
    output logic [1:0]     pc_source,
    output logic           iord,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic           instr_done,
    output logic           illegal,
    output logic [SW-1:0]  state
);

    // state     | meaning
    // FETCH     | read instr, PC+1 (only when run=1)
    // DECODE    | decode opcode, precompute branch target
    // MEM_ADDR  | effective address for lw/sw
    // MEM_READ  | data memory read
    // WB_MEM    | write loaded data to rt
    // MEM_WRITE | data memory write
    // EXEC_R    | R-type ALU operation
    // WB_R      | write ALU result to rd
    // BRANCH    | beq compare, conditional PC update
    // JUMP      | PC <- jump target
    // EXEC_I    | addi ALU operation
    // WB_I      | write ALU result to rt
    typedef enum logic [SW-1:0] {
        S_FETCH     = SW'(0),
        S_DECODE    = SW'(1),
        S_MEM_ADDR  = SW'(2),
        S_MEM_READ  = SW'(3),
        S_WB_MEM    = SW'(4),
        S_MEM_WRITE = SW'(5),
        S_EXEC_R    = SW'(6),
        S_WB_R      = SW'(7),
        S_BRANCH    = SW'(8),
        S_JUMP      = SW'(9),
        S_EXEC_I    = SW'(10),
        S_WB_I      = SW'(11)
    } state_t;

    localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

    state_t state_q, state_d;
    logic   pc_write, pc_write_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d       = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        instr_done    = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (run) begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    alu_src_b = 2'b01;
                    pc_write  = 1'b1;
                    state_d   = S_DECODE;
                end else begin
                    state_d   = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // opcode is still held in the IR, so lw/sw split happens here
                state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = S_WB_MEM;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_WB_I;
            end
            S_WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        pc_we = pc_write | (pc_write_cond & zero);

        // Reset silences every strobe so an aborted instruction cannot write anything
        if (rst) begin
            pc_we      = 1'b0;
            pc_source  = 2'b00;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed instruction sequences followed
// by randomized instruction streams against a path/table reference model.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst, run, zero;
    logic [5:0] opcode;
    logic       pc_we, iord, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, instr_done, illegal;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state;

    mc_ctrl_fsm #(.OPW(6), .SW(4)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
        .pc_we(pc_we), .pc_source(pc_source), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // {pc_we, pc_source, iord, mem_read, mem_write, ir_write, reg_dst,
    //  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, instr_done, illegal}
    logic [16:0] obs;
    assign obs = {pc_we, pc_source, iord, mem_read, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, instr_done, illegal};

    int          checks = 0;
    int          errors = 0;
    int          exp_state = 0;
    int          pending[$];
    logic [16:0] tbl[12];

    function automatic logic [16:0] mk(logic pcw, logic [1:0] pcs, logic io, logic mr,
                                       logic mw, logic irw, logic rd, logic m2r, logic rw,
                                       logic asa, logic [1:0] asb, logic [1:0] aop, logic dn);
        return {pcw, pcs, io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, dn, 1'b0};
    endfunction

    function automatic logic is_legal(logic [5:0] o);
        return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // States visited after FETCH, by instruction class
    function void load_path(logic [5:0] o);
        pending.delete();
        case (o)
            6'b000000: pending = '{1, 6, 7};
            6'b100011: pending = '{1, 2, 3, 4};
            6'b101011: pending = '{1, 2, 5};
            6'b000100: pending = '{1, 8};
            6'b001000: pending = '{1, 10, 11};
            6'b000010: pending = '{1, 9};
            default:   pending = '{1};
        endcase
    endfunction

    function automatic logic [16:0] expected(int st);
        logic [16:0] v;
        if (rst) return '0;
        v = tbl[st];
        if (st == 0 && !run) v = '0;
        if (st == 8 && zero) v[16] = 1'b1;
        if (st == 1 && !is_legal(opcode)) v[0] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag);
        logic [16:0] e;
        logic [3:0]  es;
        e  = expected(exp_state);
        es = 4'(exp_state);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s outs: observed %h expected %h (state %0d)", tag, obs, e, exp_state);
        end
        checks++;
        assert (state === es) else begin
            errors++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, es);
        end
    endtask

    task automatic step(input logic r, input logic z, input string tag);
        run  = r;
        zero = z;
        @(negedge clk);
        check(tag);
        @(posedge clk);
        if (exp_state == 0) begin
            if (run) begin
                load_path(opcode);
                exp_state = pending.pop_front();
            end
        end else if (pending.size() > 0) begin
            exp_state = pending.pop_front();
        end else begin
            exp_state = 0;
        end
        #1;
    endtask

    // zmode: 0/1 fixed zero flag, 2 random per cycle
    task automatic do_instr(input logic [5:0] opc, input int zmode, input string tag);
        int n;
        opcode = opc;
        n = 0;
        step(1'b1, (zmode == 2) ? 1'($urandom) : 1'(zmode), tag);
        while (exp_state != 0 && n < 10) begin
            step(1'b1, (zmode == 2) ? 1'($urandom) : 1'(zmode), tag);
            n++;
        end
        checks++;
        assert (n < 10) else begin
            errors++;
            $error("FAIL %s timeout: observed %0d cycles expected <10", tag, n);
        end
    endtask

    initial begin
        tbl[0]  = mk(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0);
        tbl[1]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0);
        tbl[2]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0);
        tbl[3]  = mk(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        tbl[4]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1);
        tbl[5]  = mk(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        tbl[6]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0);
        tbl[7]  = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 1);
        tbl[8]  = mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1);
        tbl[9]  = mk(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        tbl[10] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0);
        tbl[11] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1);

        rst = 1'b1; run = 1'b1; zero = 1'b1; opcode = 6'b100011;
        #2;
        check("reset_async");
        @(posedge clk); #1;
        check("reset_held");
        rst = 1'b0;

        do_instr(6'b100011, 2, "lw");
        do_instr(6'b000100, 1, "beq_taken");
        do_instr(6'b000100, 0, "beq_not_taken");
        do_instr(6'b101011, 1, "sw");
        do_instr(6'b000010, 0, "j");
        do_instr(6'b111111, 1, "illegal");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "run_low");
        do_instr(6'b001000, 2, "addi");

        // Reset mid EXEC_R: abort before WB_R
        opcode = 6'b000000;
        step(1'b1, 1'b1, "r_pre_rst");
        step(1'b1, 1'b1, "r_pre_rst");
        #2;
        rst = 1'b1;
        exp_state = 0;
        pending.delete();
        #1;
        check("rst_mid_exec_r");
        @(negedge clk);
        check("rst_mid_hold");
        @(posedge clk); #1;
        check("rst_mid_edge");
        rst = 1'b0;
        do_instr(6'b000000, 2, "r_after_rst");

        for (int i = 0; i < 80; i++) begin
            logic [5:0] o;
            int idle;
            case ($urandom_range(0, 6))
                0: o = 6'b000000;
                1: o = 6'b100011;
                2: o = 6'b101011;
                3: o = 6'b000100;
                4: o = 6'b001000;
                5: o = 6'b000010;
                default: begin
                    o = 6'($urandom);
                    while (is_legal(o)) o = 6'($urandom);
                end
            endcase
            idle = $urandom_range(0, 2);
            opcode = o;
            for (int k = 0; k < idle; k++) step(1'b0, 1'($urandom), "rand_idle");
            do_instr(o, 2, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multicycle control FSM that sits directly upstream of the 8-bit PC register. It produces the PC write enable (pc_we) and the next-PC source select (pc_source), plus all datapath strobes for a MIPS subset: R-type, lw, sw, beq, addi, j. It is a Moore machine on a registered 4-bit state, with two exceptions: pc_we (depends on zero) and FETCH-state run gating (depends on run).

Parameters:
OPW, 6, opcode width.
SW, 4, state register width.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  reset, asynchronous, active-high.
run  in  1  1 = permit new instruction fetch; sampled only in FETCH.
opcode  in  OPW  instr[31:26] from instruction register; valid from DECODE onward.
zero  in  1  ALU zero flag, combinational, same cycle.
pc_we  out  1  PC write enable = pc_write | (pc_write_cond & zero).
pc_source  out  2  next-PC select: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
iord  out  1  memory address select: 0 PC, 1 ALUOut.
mem_read  out  1  memory read strobe.
mem_write  out  1  memory write strobe.
ir_write  out  1  instruction register load.
reg_dst  out  1  write register: 0 rt, 1 rd.
mem_to_reg  out  1  write-back data: 0 ALUOut, 1 MDR.
reg_write  out  1  register file write.
alu_src_a  out  1  ALU A: 0 PC, 1 reg A.
alu_src_b  out  2  ALU B: 00 reg B, 01 constant 1, 10 sign-extended imm, 11 branch offset.
alu_op  out  2  00 add, 01 sub, 10 funct-decoded.
instr_done  out  1  high during the final cycle of each instruction.
illegal  out  1  high in DECODE when opcode is unsupported.
state  out  SW  current state, for debug display.

Behaviour:
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States and encodings, with outputs. Any output not listed is 0.
  - FETCH=0: mem_read, ir_write, alu_src_b=01, pc_write. Outputs are active only when run=1.
  - DECODE=1: alu_src_b=11.
  - MEM_ADDR=2: alu_src_a=1, alu_src_b=10.
  - MEM_READ=3: mem_read, iord.
  - WB_MEM=4: reg_write, mem_to_reg.
  - MEM_WRITE=5: mem_write, iord.
  - EXEC_R=6: alu_src_a=1, alu_op=10.
  - WB_R=7: reg_write, reg_dst.
  - BRANCH=8: alu_src_a=1, alu_op=01, pc_write_cond, pc_source=01.
  - JUMP=9: pc_write, pc_source=10.
  - EXEC_I=10: alu_src_a=1, alu_src_b=10.
  - WB_I=11: reg_write.
- Transitions:
  - FETCH→DECODE if run, else stay in FETCH.
  - DECODE → MEM_ADDR for lw/sw, EXEC_R for R, BRANCH for beq, EXEC_I for addi, JUMP for j. Any other opcode → FETCH with illegal=1 for that cycle.
  - MEM_ADDR → MEM_READ for lw, MEM_WRITE for sw (opcode re-read here).
  - MEM_READ→WB_MEM.
  - EXEC_R→WB_R.
  - EXEC_I→WB_I.
  - WB_MEM, MEM_WRITE, WB_R, BRANCH, JUMP, WB_I → FETCH.
  - Encodings 12-15 → FETCH, all outputs 0.
- Latency in cycles, FETCH included: lw 5; sw 4; R 4; addi 4; beq 3; j 3; illegal 2.
- instr_done=1 in WB_MEM, MEM_WRITE, WB_R, BRANCH, JUMP, WB_I.
- pc_we: exactly one pulse per instruction from FETCH (PC+1), one from JUMP, and one from BRANCH only when zero=1.
  - pc_we must never assert in any other state, whatever the value of zero.
- run=0 in FETCH: no ir_write, no pc_we, no mem_read; the FSM holds. run is ignored in all other states, so an in-flight instruction always completes.
- Reset:
  - rst asserts state=FETCH immediately, asynchronously.
  - While rst=1, every output except state is forced to 0, including pc_we.
  - Reset mid-instruction aborts it; no further register or memory writes occur.
  - After release, the first fetch happens on the first edge with run=1.

Test Plan:
- rst=1 with run=1 → pc_we=0, ir_write=0, state=0. Release rst with run=1 → FETCH cycle has pc_we=1, mem_read=1, ir_write=1; next state=1.
- lw (100011), run=1 → states 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4; instr_done high only there.
- beq (000100): zero=1 in BRANCH → pc_we=1, pc_source=01. Repeat with zero=0 → pc_we=0, and the next state is still FETCH.
- sw then j → sw: states 0,1,2,5 with mem_write=1, iord=1 in state 5. j: states 0,1,9 with pc_we=1, pc_source=10 in state 9.
- Opcode 111111 → DECODE has illegal=1, then FETCH. No reg_write or mem_write at any point.
- run=0 held 3 cycles in FETCH → state stays 0 and pc_we=0. rst pulsed while in EXEC_R → state=0 asynchronously, and WB_R's reg_write never occurs.
